start_signal_pio_in: RTL and testbench

START_SIGNAL_PIO_IN -- requirements
Module: start_signal_pio_in

---
 rtl/start_signal_pio_pkg.sv | 15 +
 rtl/pio_sync_edge.sv | 48 ++++
 rtl/start_signal_pio_in.sv | 74 +++++++
 tb/tb_start_signal_pio_in.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/start_signal_pio_pkg.sv
// Shared constants for the start-signal PIO: register word addresses and capture-edge selectors.
package start_signal_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_IRQ_MASK = 2'd1,
        ADDR_RESERVED = 2'd2,
        ADDR_EDGE_CAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Two-flop synchronizer, previous-sample flop and per-bit edge detector for the PIO inputs.
module pio_sync_edge
    import start_signal_pio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] raw_edges;
    logic [2:0]       armed;

    // armed[2] rises once prev holds a real sample, so levels present at reset release are not flagged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            armed <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
            armed <= {armed[1:0], 1'b1};
        end
    end

    always_comb begin
        raw_edges = sync2 & ~prev;
        case (EDGE_TYPE)
            EDGE_FALLING: raw_edges = ~sync2 & prev;
            EDGE_ANY:     raw_edges = sync2 ^ prev;
            default:      raw_edges = sync2 & ~prev;
        endcase
    end

    assign edges = armed[2] ? raw_edges : '0;
    assign data  = sync2;

endmodule

// File: rtl/start_signal_pio_in.sv
// Avalon-MM PIO input block with edge capture and masked level interrupt.
// Build option: START_SIGNAL_PIO_BIT_CLEAR_EN selects per-bit clearing of edge_capture.
module start_signal_pio_in
    import start_signal_pio_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] cap_clear;
    logic             wr_strobe;
    logic             unused_wdata;

    pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .data    (data),
        .edges   (edges)
    );

    assign wr_strobe    = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

`ifdef START_SIGNAL_PIO_BIT_CLEAR_EN
    assign cap_clear = (wr_strobe && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
`else
    assign cap_clear = (wr_strobe && address == ADDR_EDGE_CAP) ? '1 : '0;
`endif

    // New edges are OR-ed in after the clear so a simultaneous set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_strobe && address == ADDR_IRQ_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= (edge_capture & ~cap_clear) | edges;
        end
    end

    always_comb begin
        readdata = '0;
        case (pio_addr_e'(address))
            ADDR_DATA:     readdata[WIDTH-1:0] = data;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_capture;
            ADDR_RESERVED: readdata = '0;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_start_signal_pio_in.sv
// Scoreboard bench for start_signal_pio_in: a rising-edge and an any-edge instance share one bus and input port.
module tb_start_signal_pio_in;
    import start_signal_pio_pkg::*;

    localparam int RD_R  = 0;
    localparam int IRQ_R = 1;
    localparam int RD_A  = 2;
    localparam int IRQ_A = 3;

`ifdef START_SIGNAL_PIO_BIT_CLEAR_EN
    localparam logic [31:0] CLR_EXP = 32'h0000_0001;
`else
    localparam logic [31:0] CLR_EXP = 32'h0000_0000;
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [1:0]  addr;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd_rise;
    logic [31:0] rd_any;
    logic        irq_rise;
    logic        irq_any;

    sb_entry_t sb_q[$];
    int total_checks = 0;
    int bad_checks   = 0;

    start_signal_pio_in #(.WIDTH(16), .EDGE_TYPE(EDGE_RISING)) dut_rise (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_rise),
        .in_port    (in_port),
        .irq        (irq_rise)
    );

    start_signal_pio_in #(.WIDTH(16), .EDGE_TYPE(EDGE_ANY)) dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_any),
        .in_port    (in_port),
        .irq        (irq_any)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: observed %08h required %08h", tag, obs, exp);
        end
    endtask

    task automatic expectOut(input string tag, input int sel, input logic [1:0] a, input logic [31:0] e);
        sb_entry_t ent;
        ent.tag  = tag;
        ent.sel  = sel;
        ent.addr = a;
        ent.exp  = e;
        sb_q.push_back(ent);
    endtask

    // Reads are zero-latency, so each entry is sampled 1 time unit after its address is applied
    task automatic drainScoreboard();
        sb_entry_t   ent;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            address = ent.addr;
            #1;
            case (ent.sel)
                RD_R:    obs = rd_rise;
                IRQ_R:   obs = {31'b0, irq_rise};
                RD_A:    obs = rd_any;
                default: obs = {31'b0, irq_any};
            endcase
            checkOutput(ent.tag, obs, ent.exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d, input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        in_port    = 16'hFFFF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        waitClocks(2);

        expectOut("rst_data",  RD_R, ADDR_DATA,     32'h0);
        expectOut("rst_mask",  RD_R, ADDR_IRQ_MASK, 32'h0);
        expectOut("rst_resv",  RD_R, ADDR_RESERVED, 32'h0);
        expectOut("rst_cap",   RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("rst_irq",   IRQ_R, ADDR_DATA,    32'h0);
        drainScoreboard();
        waitClocks(1);
        reset_n = 1'b1;

        waitClocks(3);
        expectOut("rel_data",     RD_R, ADDR_DATA,     32'h0000_FFFF);
        expectOut("rel_cap",      RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("rel_irq",      IRQ_R, ADDR_DATA,    32'h0);
        expectOut("rel_data_any", RD_A, ADDR_DATA,     32'h0000_FFFF);
        expectOut("rel_cap_any",  RD_A, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        waitClocks(3);
        expectOut("rel_cap_late",     RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("rel_cap_late_any", RD_A, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();

        applyStimulus(ADDR_RESERVED, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(ADDR_DATA, 32'h0, 1'b1);
        applyStimulus(ADDR_IRQ_MASK, 32'h1, 1'b0);
        expectOut("resv_read",   RD_R, ADDR_RESERVED, 32'h0);
        expectOut("data_nowr",   RD_R, ADDR_DATA,     32'h0000_FFFF);
        expectOut("mask_nocs",   RD_R, ADDR_IRQ_MASK, 32'h0);
        expectOut("cap_nowr",    RD_R, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();

        in_port = 16'h0000;
        waitClocks(4);
        expectOut("fall_data",    RD_R, ADDR_DATA,     32'h0);
        expectOut("fall_cap_r",   RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("fall_cap_any", RD_A, ADDR_EDGE_CAP, 32'h0000_FFFF);
        drainScoreboard();
        applyStimulus(ADDR_EDGE_CAP, 32'h0000_FFFF, 1'b1);
        expectOut("clr_all_r",   RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("clr_all_any", RD_A, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();

        applyStimulus(ADDR_IRQ_MASK, 32'h0000_0001, 1'b1);
        expectOut("mask_wr", RD_R, ADDR_IRQ_MASK, 32'h1);
        drainScoreboard();
        in_port = 16'h0001;
        waitClocks(1);
        expectOut("lat1_data", RD_R, ADDR_DATA,     32'h0);
        expectOut("lat1_cap",  RD_R, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        waitClocks(1);
        expectOut("lat2_data", RD_R, ADDR_DATA,     32'h1);
        expectOut("lat2_cap",  RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("lat2_irq",  IRQ_R, ADDR_DATA,    32'h0);
        drainScoreboard();
        waitClocks(1);
        expectOut("lat3_cap",  RD_R, ADDR_EDGE_CAP, 32'h1);
        expectOut("lat3_irq",  IRQ_R, ADDR_DATA,    32'h1);
        drainScoreboard();
        in_port = 16'h0000;
        waitClocks(4);
        expectOut("fall_nocap", RD_R, ADDR_EDGE_CAP, 32'h1);
        expectOut("fall_data0", RD_R, ADDR_DATA,     32'h0);
        drainScoreboard();

        in_port = 16'h0005;
        waitClocks(3);
        expectOut("cap_5", RD_R, ADDR_EDGE_CAP, 32'h5);
        drainScoreboard();
        applyStimulus(ADDR_EDGE_CAP, 32'h0000_0004, 1'b1);
        expectOut("part_clr",     RD_R, ADDR_EDGE_CAP, CLR_EXP);
        expectOut("part_clr_irq", IRQ_R, ADDR_DATA,    CLR_EXP);
        drainScoreboard();

        applyStimulus(ADDR_EDGE_CAP, 32'h0000_FFFF, 1'b1);
        expectOut("clr_before_race", RD_R, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        in_port = 16'h0004;
        waitClocks(4);
        in_port = 16'h0005;
        waitClocks(2);
        // This clear lands on the same edge that captures the new bit0 rise
        applyStimulus(ADDR_EDGE_CAP, 32'h0000_FFFF, 1'b1);
        expectOut("race_cap", RD_R, ADDR_EDGE_CAP, 32'h1);
        expectOut("race_irq", IRQ_R, ADDR_DATA,    32'h1);
        drainScoreboard();
        applyStimulus(ADDR_EDGE_CAP, 32'h0000_FFFF, 1'b1);
        expectOut("after_race_clr", RD_R, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();

        applyStimulus(ADDR_IRQ_MASK, 32'h0, 1'b1);
        in_port = 16'h0007;
        waitClocks(3);
        expectOut("cap_2",       RD_R, ADDR_EDGE_CAP, 32'h2);
        expectOut("irq_masked",  IRQ_R, ADDR_DATA,    32'h0);
        drainScoreboard();
        applyStimulus(ADDR_IRQ_MASK, 32'h0000_0002, 1'b1);
        expectOut("irq_unmasked", IRQ_R, ADDR_DATA, 32'h1);
        drainScoreboard();
        #3;
        reset_n = 1'b0;
        expectOut("mid_rst_irq",     IRQ_R, ADDR_DATA,     32'h0);
        expectOut("mid_rst_irq_any", IRQ_A, ADDR_DATA,     32'h0);
        expectOut("mid_rst_data",    RD_R,  ADDR_DATA,     32'h0);
        expectOut("mid_rst_mask",    RD_R,  ADDR_IRQ_MASK, 32'h0);
        expectOut("mid_rst_resv",    RD_R,  ADDR_RESERVED, 32'h0);
        expectOut("mid_rst_cap",     RD_R,  ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        expectOut("mid_rst_data_any", RD_A, ADDR_DATA,     32'h0);
        expectOut("mid_rst_cap_any",  RD_A, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        waitClocks(1);
        reset_n = 1'b1;
        waitClocks(5);
        expectOut("hi_no_edge", RD_R, ADDR_EDGE_CAP, 32'h0);
        expectOut("hi_data",    RD_R, ADDR_DATA,     32'h7);
        drainScoreboard();

        in_port = 16'h0000;
        waitClocks(4);
        applyStimulus(ADDR_EDGE_CAP, 32'h0000_FFFF, 1'b1);
        expectOut("any_pre_clr", RD_A, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        in_port = 16'h0008;
        waitClocks(3);
        expectOut("any_rise_b3",  RD_A,  ADDR_EDGE_CAP, 32'h8);
        expectOut("rise_rise_b3", RD_R,  ADDR_EDGE_CAP, 32'h8);
        expectOut("any_irq_mask0", IRQ_A, ADDR_DATA,    32'h0);
        drainScoreboard();
        applyStimulus(ADDR_EDGE_CAP, 32'h0000_FFFF, 1'b1);
        expectOut("any_mid_clr", RD_A, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();
        in_port = 16'h0000;
        waitClocks(3);
        expectOut("any_fall_b3",  RD_A, ADDR_EDGE_CAP, 32'h8);
        expectOut("rise_fall_b3", RD_R, ADDR_EDGE_CAP, 32'h0);
        drainScoreboard();

        for (int i = 0; i < 4; i++) begin
            in_port = 16'($urandom_range(0, 65535));
            waitClocks(2);
            expectOut("rand_data",     RD_R, ADDR_DATA, {16'h0, in_port});
            expectOut("rand_data_any", RD_A, ADDR_DATA, {16'h0, in_port});
            drainScoreboard();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
